// File: rtl/bcd_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : bcd_pkg
//  Description : Shared types and constants for the sequential binary-to-BCD
//                (double-dabble) converter.
//  Revision    : 1.0 - initial release
// ============================================================================
package bcd_pkg;

  // Converter control states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam int BCD_DIGIT_W = 4;
  localparam int ADJ_THRESH  = 5;
  localparam int ADJ_ADD     = 3;

  // Number of decimal digits needed to show the largest IN_W-bit value
  function automatic int min_digits(input int in_w);
    longint unsigned v;
    int              d;
    if (in_w >= 64) v = '1;
    else            v = (64'd1 << in_w) - 64'd1;
    d = 1;
    for (int i = 0; i < 20; i++) begin
      if (v >= 64'd10) begin
        v = v / 64'd10;
        d = d + 1;
      end
    end
    return d;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bin_to_bcd_seq_if.sv
`default_nettype none
// ============================================================================
//  Interface   : bin_to_bcd_seq_if
//  Description : Start/busy/done handshake and result bus of the binary-to-BCD
//                converter. master = requester, slave = converter.
//  Revision    : 1.0 - initial release
// ============================================================================
interface bin_to_bcd_seq_if
  import bcd_pkg::*;
#(
  parameter int IN_W   = 16,
  parameter int DIGITS = 5
) ();

  logic                          load;
  logic [IN_W-1:0]               bin_in;
  logic                          busy;
  logic                          done;
  logic [BCD_DIGIT_W*DIGITS-1:0] bcd_out;
  logic [DIGITS-1:0]             blank;

  modport master (
    output load, bin_in,
    input  busy, done, bcd_out, blank
  );

  modport slave (
    input  load, bin_in,
    output busy, done, bcd_out, blank
  );

endinterface
`default_nettype wire

// File: rtl/bcd_digit_adj.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_digit_adj
//  Description : Combinational double-dabble digit correction: adds 3 to a
//                BCD digit that is 5 or more, so the following left shift
//                carries correctly into the next decimal digit.
//  Revision    : 1.0 - initial release
// ============================================================================
module bcd_digit_adj
  import bcd_pkg::*;
(
  input  wire logic [BCD_DIGIT_W-1:0] i_digit,
  output logic      [BCD_DIGIT_W-1:0] o_digit
);

  // No carry out: a digit <= 9 plus 3 never exceeds 4 bits
  assign o_digit = (i_digit >= BCD_DIGIT_W'(ADJ_THRESH))
                 ? i_digit + BCD_DIGIT_W'(ADJ_ADD)
                 : i_digit;

endmodule
`default_nettype wire

// File: rtl/bin_to_bcd_seq.sv
`default_nettype none
// ============================================================================
//  Module      : bin_to_bcd_seq
//  Description : Sequential shift-add-3 binary-to-BCD converter, one bit per
//                clock. A load accepted in IDLE runs IN_W SHIFT cycles, then
//                one DONE cycle that pulses done and presents the result.
//                Optional build macro LEADING_ZERO_BLANK_EN enables the
//                registered leading-zero blank mask; otherwise blank is 0.
//  Revision    : 1.0 - initial release
// ============================================================================
module bin_to_bcd_seq
  import bcd_pkg::*;
#(
  parameter int IN_W   = 16,
  parameter int DIGITS = 5
) (
  input wire logic         clk,
  input wire logic         rst_n,
  bin_to_bcd_seq_if.slave  bus
);

  localparam int SCR_W = BCD_DIGIT_W * DIGITS;
  localparam int CNT_W = $clog2(IN_W + 1);

  // Too few digits would silently lose the top digit's shifted-out bit
  generate
    if (DIGITS < min_digits(IN_W)) begin : g_digits_check
      $error("bin_to_bcd_seq: DIGITS too small for IN_W");
    end
  endgenerate

  state_e            state_q,   state_d;
  logic [IN_W-1:0]   shift_q,   shift_d;
  logic [SCR_W-1:0]  scratch_q, scratch_d;
  logic [CNT_W-1:0]  cnt_q,     cnt_d;
  logic [SCR_W-1:0]  bcd_q,     bcd_d;
  logic              busy_q,    busy_d;
  logic              done_q,    done_d;

  logic [SCR_W-1:0]  w_adj;
  logic [SCR_W-1:0]  w_scratch_nxt;
  logic [IN_W-1:0]   w_shift_nxt;
  logic              w_unused_msb;

  // Per-digit add-3 correction on the current scratch
  generate
    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
      bcd_digit_adj u_adj (
        .i_digit (scratch_q[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
        .o_digit (w_adj[g*BCD_DIGIT_W +: BCD_DIGIT_W])
      );
    end
  endgenerate

  // Shift {scratch, shift register} left by one; top digit's MSB is dropped
  assign {w_unused_msb, w_scratch_nxt, w_shift_nxt} = {w_adj, shift_q, 1'b0};

`ifdef LEADING_ZERO_BLANK_EN
  logic [DIGITS-1:0] blank_q, blank_d;
  logic [DIGITS-1:0] w_blank_nxt;

  // Blank digit i when it and every higher digit are zero; digit 0 always shows
  always_comb begin : blank_calc
    logic zero_above;
    w_blank_nxt = '0;
    zero_above  = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      zero_above     = zero_above & (w_scratch_nxt[i*BCD_DIGIT_W +: BCD_DIGIT_W] == '0);
      w_blank_nxt[i] = zero_above;
    end
  end
`endif

  // Next-state, datapath and output-register logic
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    scratch_d = scratch_q;
    cnt_d     = cnt_q;
    bcd_d     = bcd_q;
    done_d    = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
    blank_d   = blank_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.load) begin
          shift_d   = bus.bin_in;
          scratch_d = '0;
          cnt_d     = CNT_W'(IN_W);
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        shift_d   = w_shift_nxt;
        scratch_d = w_scratch_nxt;
        cnt_d     = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = DONE;
          bcd_d   = w_scratch_nxt;
          done_d  = 1'b1;
`ifdef LEADING_ZERO_BLANK_EN
          blank_d = w_blank_nxt;
`endif
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and output registers with asynchronous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      scratch_q <= '0;
      cnt_q     <= '0;
      bcd_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
      blank_q   <= '0;
`endif
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      scratch_q <= scratch_d;
      cnt_q     <= cnt_d;
      bcd_q     <= bcd_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
`ifdef LEADING_ZERO_BLANK_EN
      blank_q   <= blank_d;
`endif
    end
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.bcd_out = bcd_q;
`ifdef LEADING_ZERO_BLANK_EN
  assign bus.blank   = blank_q;
`else
  assign bus.blank   = '0;
`endif

endmodule
`default_nettype wire
